reg_mem_xfer_unit: RTL
======================

Name: reg_mem_xfer_unit

Overview:
Parametrised register-bank/memory transfer engine with a command handshake. It moves words between an immediate operand, an internal register file and an internal synchronous single-port memory. The memory has a 1-cycle read latency, matching block-RAM timing. It replaces the opcode-edge-triggered transfer logic with an explicit start/busy/done protocol, full-width registers, error reporting, a memory-to-memory copy op and a debug register read port.

Parameters:
DATA_W, 32, word width of memory, registers, immediate and read data
ADDR_W, 4, memory address width; depth = 2**ADDR_W words
NREGS, 8, number of registers in the register file (power of two, >=2)
REG_AW, $clog2(NREGS), register address width (derived)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command request; accepted only in IDLE
opcode  input  3  command: 0 STORE_IMM, 1 STORE_REG, 2 LOAD_REG, 3 READ_MEM, 4 COPY_MEM, 5-7 illegal
reg_addr  input  REG_AW  register operand
mem_addr  input  ADDR_W  memory source/target address
mem_addr2  input  ADDR_W  COPY_MEM destination address
imm_data  input  DATA_W  STORE_IMM operand
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = illegal opcode
rd_data  output  DATA_W  READ_MEM result, held until next READ_MEM completes
rd_valid  output  1  one-cycle pulse with done for READ_MEM only
dbg_reg_addr  input  REG_AW  debug register select
dbg_reg_data  output  DATA_W  combinational regs[dbg_reg_addr]

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy, done, err, rd_valid = 0; rd_data = 0; all registers = 0. Memory contents are not reset.
- Command accept: in IDLE with start=1 at a rising edge, latch opcode, reg_addr, mem_addr, mem_addr2, imm_data. Inputs are don't-care afterwards.
- start while busy: ignored, no queueing.
- States: IDLE, EXEC, RDWAIT, WB, DONE, with the following paths:
  - STORE_IMM / STORE_REG: IDLE->EXEC->DONE. Memory write of imm_data or regs[reg_addr] at the end of EXEC.
  - LOAD_REG / READ_MEM: IDLE->EXEC->RDWAIT->DONE. Read address issued in EXEC; data valid in RDWAIT.
    - LOAD_REG writes regs[reg_addr] at the end of RDWAIT.
    - READ_MEM loads rd_data at the end of RDWAIT.
  - COPY_MEM: IDLE->EXEC->RDWAIT->WB->DONE. Source read as above, captured internally at the end of RDWAIT, written to mem[mem_addr2] at the end of WB.
  - Illegal opcode: IDLE->DONE with err=1; no memory or register change.
- Latency (start edge to done high): 1 cycle for illegal; 2 for stores; 3 for LOAD_REG/READ_MEM; 4 for COPY_MEM.
- DONE lasts exactly one cycle: done=1, err per command, rd_valid=1 iff READ_MEM; then IDLE. Back-to-back: start may be high in the cycle after DONE (IDLE); DONE itself does not accept.
- COPY_MEM with mem_addr==mem_addr2: legal, memory unchanged.
- The memory read in EXEC returns the value from before any write of the same command; no command reads and writes in the same cycle.
- Widths: registers and memory are full DATA_W; no truncation anywhere.
- Reset mid-command: abort immediately; no partial write completes after rst_n deasserts; done not pulsed.

Test Plan:
- Reset with rst_n=0 mid-COPY_MEM -> busy=0, done=0, dbg_reg_data=0 for every register; the destination word keeps its prior value.
- STORE_IMM imm=10 mem 1; LOAD_REG reg 4 mem 1 -> done 2 then 3 cycles after start; dbg_reg_addr=4 gives 10, err=0.
- STORE_REG reg 4 mem 3; READ_MEM mem 3 -> rd_valid with done 3 cycles after start, rd_data=10; rd_data holds through the following STORE_IMM.
- STORE_IMM 0xDEADBEEF mem 15; COPY_MEM 15->0; READ_MEM 0 -> 0xDEADBEEF (full-width, top-address wrap-free); copy done 4 cycles after start.
- opcode=6 -> done 1 cycle after start with err=1; a memory/register dump is unchanged.
- start held high continuously across commands -> each command accepted only in IDLE; busy never drops inside a command; toggling start while busy has no effect.

Source files
------------

// File: rtl/reg_mem_xfer_unit.sv
// Register-file / memory transfer engine with start/busy/done handshake.
// The internal single-port memory has a 1-cycle registered read.
module reg_mem_xfer_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 8,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [REG_AW-1:0] reg_addr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] mem_addr2,
  input  logic [DATA_W-1:0] imm_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [REG_AW-1:0] dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [2:0] OP_STIMM = 3'd0;
  localparam logic [2:0] OP_STREG = 3'd1;
  localparam logic [2:0] OP_LDREG = 3'd2;
  localparam logic [2:0] OP_RDMEM = 3'd3;
  localparam logic [2:0] OP_COPY  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_RDWAIT, S_WB, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] ma_q, ma_d;
  logic [ADDR_W-1:0] ma2_q, ma2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] copy_q, copy_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_rdata_q;

  logic              acc;
  logic              is_store;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign acc      = (state_q == S_IDLE) && start;
  assign is_store = (op_q == OP_STIMM) || (op_q == OP_STREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_d = (opcode > OP_COPY) ? S_DONE : S_EXEC;
      end
      S_EXEC:   state_d = is_store ? S_DONE : S_RDWAIT;
      S_RDWAIT: state_d = (op_q == OP_COPY) ? S_WB : S_DONE;
      S_WB:     state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = done && err_q;
    rd_valid  = done && (op_q == OP_RDMEM);
    mem_re    = (state_q == S_EXEC) && !is_store;
    mem_we    = ((state_q == S_EXEC) && is_store) || (state_q == S_WB);
    mem_waddr = (state_q == S_WB) ? ma2_q : ma_q;
    mem_wdata = imm_q;
    if (state_q == S_WB)      mem_wdata = copy_q;
    else if (op_q == OP_STREG) mem_wdata = regs_q[ra_q];
  end

  always_comb begin
    op_d      = op_q;
    ra_d      = ra_q;
    ma_d      = ma_q;
    ma2_d     = ma2_q;
    imm_d     = imm_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    copy_d    = copy_q;
    regs_d    = regs_q;
    if (acc) begin
      op_d  = opcode;
      ra_d  = reg_addr;
      ma_d  = mem_addr;
      ma2_d = mem_addr2;
      imm_d = imm_data;
      err_d = (opcode > OP_COPY);
    end
    if (state_q == S_RDWAIT) begin
      unique case (1'b1)
        op_q == OP_LDREG: regs_d[ra_q] = mem_rdata_q;
        op_q == OP_RDMEM: rd_data_d    = mem_rdata_q;
        op_q == OP_COPY:  copy_d       = mem_rdata_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      ra_q      <= '0;
      ma_q      <= '0;
      ma2_q     <= '0;
      imm_q     <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      copy_q    <= '0;
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      op_q      <= op_d;
      ra_q      <= ra_d;
      ma_q      <= ma_d;
      ma2_q     <= ma2_d;
      imm_q     <= imm_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      copy_q    <= copy_d;
      regs_q    <= regs_d;
    end
  end

  // Block-RAM style array: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata_q <= mem_q[ma_q];
  end

  assign rd_data      = rd_data_q;
  assign dbg_reg_data = regs_q[dbg_reg_addr];

endmodule
